// File: rtl/avg_frame_sched_if.sv
// Stream-monitor and FIFO-write bundle for the frame-average scheduler.
// Video handshake: a beat is transferred only in a cycle where vid_tvalid and
// vid_tready are both high; tuser/tlast are meaningful only in such cycles.
// FIFO write: fifo_wr_en is a one-cycle strobe, only ever raised while
// fifo_wr_full is low, and fifo_wr_data is valid in that cycle.
interface avg_frame_sched_if;
    logic        vid_tvalid;
    logic        vid_tready;
    logic        vid_tuser;
    logic        vid_tlast;
    logic [23:0] fifo_wr_data;
    logic        fifo_wr_en;
    logic        fifo_wr_full;

    // Environment side: owns the video stream and the FIFO status.
    modport master (
        output vid_tvalid, vid_tready, vid_tuser, vid_tlast, fifo_wr_full,
        input  fifo_wr_data, fifo_wr_en
    );

    // Scheduler side: watches the stream, writes the FIFO.
    modport slave (
        input  vid_tvalid, vid_tready, vid_tuser, vid_tlast, fifo_wr_full,
        output fifo_wr_data, fifo_wr_en
    );
endinterface

// File: rtl/avg_frame_sched.sv
// Frame-average scheduler: tracks pixel position on the monitored stream,
// strobes the averager (clear / pixel enable / end of frame), and pushes every
// (frame_skip+1)-th settled average into the colour FIFO.
module avg_frame_sched #(
    parameter int H_ACTIVE   = 1920,
    parameter int V_ACTIVE   = 1080,
    parameter int SETTLE_CYC = 4
) (
    input  logic                    aclk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              frame_skip,
    input  logic [10:0]             roi_x0,
    input  logic [10:0]             roi_x1,
    input  logic [10:0]             roi_y0,
    input  logic [10:0]             roi_y1,
    avg_frame_sched_if.slave        bus,
    output logic                    avg_clear,
    output logic                    avg_pix_en,
    output logic                    avg_eof,
    input  logic [23:0]             avg_in,
    output logic [15:0]             frame_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    sync_err,
    output logic                    busy,
    output logic [1:0]              dbg_state
);
    localparam logic [10:0] X_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST    = 11'(V_ACTIVE - 1);
    localparam logic [3:0]  SETTLE_LD = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        SKIP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] x, y, x_nxt, y_nxt;
    logic [10:0] pix_x, pix_y;
    logic [3:0]  skip_cnt, skip_nxt;
    logic [3:0]  settle_cnt;
    logic [23:0] pending;
    logic        pending_valid;
    logic        beat, pix_act, set_err;
    logic        capture, write, drop_inc;

    assign beat = bus.vid_tvalid & bus.vid_tready;

    // Next-state, position update and beat-qualified averager strobes.
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        skip_nxt  = skip_cnt;
        pix_x     = x;
        pix_y     = y;
        pix_act   = 1'b0;
        set_err   = 1'b0;
        avg_clear = 1'b0;
        avg_eof   = 1'b0;
        if (beat) begin
            if (bus.vid_tuser) begin
                // SOF, either from IDLE or cutting a frame short; the beat
                // itself is pixel (0,0) of the new frame.
                set_err = (state != IDLE);
                pix_x   = 11'd0;
                pix_y   = 11'd0;
                if (enable) begin
                    x_nxt = 11'd1;
                    y_nxt = 11'd0;
                    if (skip_cnt == 4'd0) begin
                        state_nxt = ACTIVE;
                        skip_nxt  = frame_skip;
                        avg_clear = 1'b1;
                        pix_act   = 1'b1;
                    end else begin
                        state_nxt = SKIP;
                        skip_nxt  = skip_cnt - 4'd1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end else if (state != IDLE) begin
                pix_act = (state == ACTIVE);
                if (bus.vid_tlast) begin
                    set_err = (x != X_LAST);
                    x_nxt   = 11'd0;
                    y_nxt   = (y == 11'h7FF) ? y : y + 11'd1;
                    if (y == Y_LAST) begin
                        state_nxt = IDLE;
                        avg_eof   = (state == ACTIVE);
                    end
                end else begin
                    x_nxt = (x == 11'h7FF) ? x : x + 11'd1;
                end
            end
        end
        avg_pix_en = pix_act & (pix_x >= roi_x0) & (pix_x <= roi_x1)
                             & (pix_y >= roi_y0) & (pix_y <= roi_y1);
    end

    // Frame FSM and pixel position registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state    <= IDLE;
            x        <= 11'd0;
            y        <= 11'd0;
            skip_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            x        <= x_nxt;
            y        <= y_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    // Sticky framing error.
    always_ff @(posedge aclk) begin
        if (reset)        sync_err <= 1'b0;
        else if (set_err) sync_err <= 1'b1;
    end

    // A new end-of-frame pre-empts a capture due in the same cycle; that
    // earlier frame is then counted as dropped via the restart path.
    assign capture  = (settle_cnt == 4'd1) & ~avg_eof;
    assign write    = pending_valid & ~bus.fifo_wr_full;
    assign drop_inc = (avg_eof & (settle_cnt != 4'd0))
                    | (capture & pending_valid & ~write);

    // Settle countdown, result capture, FIFO push and statistics.
    always_ff @(posedge aclk) begin
        if (reset) begin
            settle_cnt    <= 4'd0;
            pending       <= 24'd0;
            pending_valid <= 1'b0;
            frame_cnt     <= 16'd0;
            drop_cnt      <= 16'd0;
        end else begin
            if (avg_eof)                 settle_cnt <= SETTLE_LD;
            else if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;

            if (capture) begin
                pending       <= avg_in;
                pending_valid <= 1'b1;
            end else if (write) begin
                pending_valid <= 1'b0;
            end

            if (write && frame_cnt != 16'hFFFF)   frame_cnt <= frame_cnt + 16'd1;
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt  <= drop_cnt + 16'd1;
        end
    end

    assign bus.fifo_wr_en   = write;
    assign bus.fifo_wr_data = pending;
    assign busy             = (state != IDLE) | (settle_cnt != 4'd0) | pending_valid;
    assign dbg_state        = state;
endmodule

// File: tb/tb_avg_frame_sched.sv
// Bench for avg_frame_sched: directed frames on a tiny 8x4 raster with a
// scoreboard of per-beat strobes and FIFO writes checked by a monitor.
module tb_avg_frame_sched;
    localparam int H = 8;
    localparam int V = 4;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  frame_skip = 4'd0;
    logic [10:0] roi_x0 = 11'd0, roi_x1 = 11'd7, roi_y0 = 11'd0, roi_y1 = 11'd3;
    logic [23:0] avg_in = 24'd0;
    logic        avg_clear, avg_pix_en, avg_eof;
    logic [15:0] frame_cnt, drop_cnt;
    logic        sync_err, busy;
    logic [1:0]  dbg_state;

    avg_frame_sched_if bus ();

    avg_frame_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .SETTLE_CYC(2)) dut (
        .aclk(aclk), .reset(reset), .enable(enable), .frame_skip(frame_skip),
        .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
        .bus(bus), .avg_clear(avg_clear), .avg_pix_en(avg_pix_en),
        .avg_eof(avg_eof), .avg_in(avg_in), .frame_cnt(frame_cnt),
        .drop_cnt(drop_cnt), .sync_err(sync_err), .busy(busy),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 aclk = ~aclk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] beat_q[$];
    logic [23:0] exp_q[$];
    int         cyc = 0;
    int         eof_cyc = 0;
    bit         lat_chk = 1'b0;
    bit         stall_en = 1'b0;
    int         pix_cnt = 0;
    int         exp_frames = 0;
    int         exp_drops = 0;
    logic [2:0] exp_strobe;
    logic [23:0] exp_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: strobes per beat, FIFO writes against the expected queue
    always @(negedge aclk) begin
        cyc++;
        if (!reset) begin
            if (bus.vid_tvalid && bus.vid_tready) begin
                if (avg_pix_en) pix_cnt++;
                if (avg_eof) eof_cyc = cyc;
                check("beat_expected", 32'(beat_q.size() != 0), 32'd1);
                if (beat_q.size() != 0) begin
                    exp_strobe = beat_q.pop_front();
                    check("strobes", 32'({avg_clear, avg_pix_en, avg_eof}), 32'(exp_strobe));
                end
            end else begin
                check("strobes_idle", 32'({avg_clear, avg_pix_en, avg_eof}), 32'd0);
            end
            if (bus.fifo_wr_en) begin
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_data = exp_q.pop_front();
                    check("wr_data", 32'(bus.fifo_wr_data), 32'(exp_data));
                end
                if (lat_chk) check("wr_latency", 32'(cyc - eof_cyc), 32'd3);
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        bus.vid_tvalid = 1'b0;
        bus.vid_tready = 1'b0;
        bus.vid_tuser  = 1'b0;
        bus.vid_tlast  = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic tu, input logic tl, input logic [2:0] e);
        beat_q.push_back(e);
        if (stall_en) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.vid_tvalid = 1'($urandom_range(0, 1));
                bus.vid_tready = bus.vid_tvalid ? 1'b0 : 1'($urandom_range(0, 1));
                bus.vid_tuser  = 1'($urandom_range(0, 1));
                bus.vid_tlast  = 1'($urandom_range(0, 1));
                @(posedge aclk);
                #1;
            end
        end
        bus.vid_tvalid = 1'b1;
        bus.vid_tready = 1'b1;
        bus.vid_tuser  = tu;
        bus.vid_tlast  = tl;
        @(posedge aclk);
        #1;
    endtask

    function automatic bit in_roi(input int x, input int y);
        return x >= int'(roi_x0) && x <= int'(roi_x1) && y >= int'(roi_y0) && y <= int'(roi_y1);
    endfunction

    // Sends one frame; row0_len shortens the first line, stop_after>0 cuts the
    // frame after that many beats (no tlast on the final row).
    task automatic send_frame(input bit proc, input logic [23:0] val,
                              input int row0_len, input int stop_after);
        int n = 0;
        for (int yy = 0; yy < V; yy++) begin
            int len = (yy == 0) ? row0_len : H;
            for (int xx = 0; xx < len; xx++) begin
                logic tu, tl, last;
                if (stop_after != 0 && n == stop_after) return;
                tu   = (n == 0);
                tl   = (xx == len - 1);
                last = tl && (yy == V - 1);
                if (n == 2) avg_in = val;
                drive_beat(tu, tl, {proc && tu, proc && in_roi(xx, yy), proc && last});
                n++;
            end
        end
    endtask

    task automatic check_counters(input string tag);
        @(negedge aclk);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drops));
        @(posedge aclk);
        #1;
    endtask

    initial begin
        idle(0);
        bus.fifo_wr_full = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        check("rst_clear", 32'(avg_clear), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge aclk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
        idle(2);

        // 1: nominal frame, write three cycles after avg_eof
        lat_chk = 1'b1;
        exp_q.push_back(24'h102030);
        send_frame(1'b1, 24'h102030, H, 0);
        exp_frames++;
        idle(8);
        lat_chk = 1'b0;
        check_counters("nominal");
        @(negedge aclk);
        check("nominal_busy", 32'(busy), 32'd0);
        @(posedge aclk);
        #1;

        // 2: windowed ROI, then an empty ROI which is still captured
        roi_x0 = 11'd2; roi_x1 = 11'd5; roi_y0 = 11'd1; roi_y1 = 11'd2;
        pix_cnt = 0;
        exp_q.push_back(24'hAA0001);
        send_frame(1'b1, 24'hAA0001, H, 0);
        exp_frames++;
        idle(6);
        check("roi_pix_cnt", 32'(pix_cnt), 32'd8);
        roi_x0 = 11'd6; roi_x1 = 11'd3; roi_y0 = 11'd0; roi_y1 = 11'd3;
        pix_cnt = 0;
        exp_q.push_back(24'hAA0002);
        send_frame(1'b1, 24'hAA0002, H, 0);
        exp_frames++;
        idle(6);
        check("empty_roi_pix_cnt", 32'(pix_cnt), 32'd0);
        check_counters("roi");
        roi_x0 = 11'd0; roi_x1 = 11'd7; roi_y0 = 11'd0; roi_y1 = 11'd3;

        // 3: frame_skip=2 over six continuous frames
        frame_skip = 4'd2;
        for (int f = 0; f < 6; f++) begin
            logic [23:0] v;
            v = 24'hB00000 | 24'(f);
            if (f % 3 == 0) begin
                exp_q.push_back(v);
                exp_frames++;
            end
            send_frame(f % 3 == 0, v, H, 0);
        end
        idle(6);
        check_counters("skip");
        frame_skip = 4'd0;

        // 4: FIFO full over three frames, only the last survives
        bus.fifo_wr_full = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(1'b1, 24'hC00000 | 24'(f), H, 0);
        exp_drops = exp_drops + 2;
        idle(6);
        check_counters("full_hold");
        exp_q.push_back(24'hC00002);
        bus.fifo_wr_full = 1'b0;
        exp_frames++;
        idle(4);
        check_counters("full_release");

        // 5: short first line, then an early SOF at (3,2)
        exp_q.push_back(24'hD00001);
        send_frame(1'b1, 24'hD00001, 6, 0);
        exp_frames++;
        idle(5);
        @(negedge aclk);
        check("short_line_sync_err", 32'(sync_err), 32'd1);
        @(posedge aclk);
        #1;
        send_frame(1'b1, 24'hD0DEAD, H, 2 * H + 3);
        exp_q.push_back(24'hD00002);
        send_frame(1'b1, 24'hD00002, H, 0);
        exp_frames++;
        idle(6);
        check_counters("early_sof");

        // 6: stalled stream, then reset while the result is settling
        stall_en = 1'b1;
        send_frame(1'b1, 24'hE00001, H, 0);
        reset = 1'b1;
        bus.vid_tvalid = 1'b0;
        bus.vid_tready = 1'b0;
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst2_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst2_sync_err", 32'(sync_err), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("rst2_strobes", 32'({avg_clear, avg_pix_en, avg_eof}), 32'd0);
        @(posedge aclk);
        #1;
        reset = 1'b0;
        exp_frames = 0;
        exp_drops  = 0;
        idle(10);
        check_counters("post_reset_quiet");
        exp_q.push_back(24'hE00002);
        send_frame(1'b1, 24'hE00002, H, 0);
        exp_frames++;
        stall_en = 1'b0;
        idle(8);
        check_counters("post_reset_frame");

        check("beat_q_drained", 32'(beat_q.size()), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/avg_frame_sched.md
Name: avg_frame_sched

Overview:
- Sequences the frame averager on the pixel-clock AXI4-Stream video path.
- Monitors the accepted video beats and tracks pixel position.
- Drives the averager's clear, pixel-enable (region of interest) and end-of-frame strobes.
- Selects every (frame_skip+1)-th frame, captures the settled average, and pushes it into the 24-bit write side of the averaged-colour CDC FIFO with full back-pressure and drop accounting.

Parameters:
- H_ACTIVE, 1920, pixels per line.
- V_ACTIVE, 1080, lines per frame.
- SETTLE_CYC, 4, cycles from avg_eof until avg_in is valid (1..15).

Ports:
- aclk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allow new frames to start.
- frame_skip  in  4  frames skipped between processed frames; sampled at each accepted SOF.
- roi_x0, roi_x1, roi_y0, roi_y1  in  11 each  inclusive ROI bounds.
- vid_tvalid, vid_tready, vid_tuser, vid_tlast  in  1 each  monitored stream handshake.
- avg_clear  out  1  restart accumulation with the current beat.
- avg_pix_en  out  1  current beat contributes to the average.
- avg_eof  out  1  last beat of a processed frame.
- avg_in  in  24  averager result {R,G,B}.
- fifo_wr_data  out  24  FIFO write data.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_full  in  1  FIFO full.
- frame_cnt  out  16  results written; saturates at 0xFFFF.
- drop_cnt  out  16  results overwritten before write; saturates at 0xFFFF.
- sync_err  out  1  sticky framing error.
- busy  out  1  state is not IDLE, or a capture/push is outstanding.

Behaviour:
- Reset values: every output 0; x=y=0; skip_cnt=0; state IDLE; settle counter idle; pending_valid=0. Reset mid-operation discards the pending result and aborts the frame with no strobes.
- beat = vid_tvalid & vid_tready. Nothing advances without a beat.
- The strobe outputs avg_clear, avg_pix_en and avg_eof are combinational from state, registered x/y and the current beat. They are valid only in beat cycles.
- States: IDLE, ACTIVE (processing), SKIP (tracking only).
- IDLE:
  - Beat with tuser and enable, skip_cnt==0 -> ACTIVE; skip_cnt<=frame_skip; avg_clear=1 this beat.
  - Beat with tuser and enable, skip_cnt!=0 -> SKIP; skip_cnt--.
  - Any other beat is ignored.
  - That SOF beat is pixel (0,0); x<=1.
- ACTIVE/SKIP, per beat:
  - Without tlast: x++ (saturate at 2047).
  - With tlast: if x!=H_ACTIVE-1, set sync_err. Then x<=0, y++.
- avg_pix_en = ACTIVE & beat & roi_x0<=x<=roi_x1 & roi_y0<=y<=roi_y1. This also applies to the SOF beat. An empty ROI (x0>x1 or y0>y1) is legal: the frame is still captured.
- Frame end is a beat with tlast & y==V_ACTIVE-1.
  - ACTIVE: assert avg_eof, start the settle counter, go IDLE.
  - SKIP: go IDLE silently.
- tuser beat while in ACTIVE/SKIP (early SOF):
  - Set sync_err and abort the current frame; it is not captured.
  - Re-evaluate this beat exactly as an IDLE SOF: enable and skip rules apply, and avg_clear asserts if the new state is ACTIVE.
- Continuous video with no blanking is supported: the SOF beat may arrive the cycle after frame end while the settle counter runs.
- Settle counter: loads SETTLE_CYC at avg_eof and counts down. On the cycle it reaches 0: pending<=avg_in, pending_valid<=1.
  - If pending_valid was already 1 and no write occurs that cycle, drop_cnt++ (old result overwritten).
  - A new avg_eof while the counter runs restarts it; the first frame is lost and drop_cnt++.
- Push: pending_valid & !fifo_wr_full -> fifo_wr_en=1 for one cycle, fifo_wr_data=pending (registered), pending_valid<=0, frame_cnt++.
  - If full, hold and retry every cycle.
  - Push and capture in the same cycle: the old value is written, the new one is loaded, no drop.
- enable low mid-frame: the current frame completes and is captured; later SOFs are ignored.
- sync_err clears only on reset.

Test Plan:
1. Nominal: H_ACTIVE=8, V_ACTIVE=4, SETTLE_CYC=2, frame_skip=0, ROI (0..7, 0..3), continuous 32-beat frames, fifo_wr_full=0, avg_in=24'h102030.
   - avg_clear on beat 0 and avg_pix_en on all 32 beats.
   - avg_eof on beat 31.
   - fifo_wr_en 3 cycles after avg_eof, data 24'h102030; frame_cnt=1.
2. ROI x 2..5, y 1..2 -> exactly 8 avg_pix_en pulses per frame, at (2..5,1) and (2..5,2). ROI x0=6, x1=3 -> 0 pulses, result still written.
3. frame_skip=2 over 6 frames -> frames 0 and 3 processed; frame_cnt=2; no strobes during SKIP.
4. fifo_wr_full held high across 3 processed frames, then released -> single write carrying the 3rd frame's value; drop_cnt=2; frame_cnt=1.
5. tlast at x=5 -> sync_err=1 and y advances. tuser at (3,2) mid-frame -> frame aborted, avg_clear on that beat, no write for the aborted frame.
6. Random tvalid/tready stalls, then reset asserted during settle -> all outputs 0 next cycle; no fifo_wr_en thereafter until a new frame completes.
